tdm_demux_1_4: RTL and testbench

- Receive-side counterpart of the 4:1 mux path.
- A TDM transmitter drives one lane per slot, with sel stepping 0,1,2,3. This block takes that serial slot stream and deposits slot i into lane i.
- It presents each complete 4-lane frame as one registered word, using a valid/ready handshake.
- It tracks frame alignment from a start-of-frame marker and recovers from misalignment.

---
 rtl/tdm_demux_1_4_if.sv | 22 ++
 rtl/tdm_demux_1_4.sv | 127 ++++++++++++
 tb/tb_tdm_demux_1_4.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_1_4_if.sv
// Slot-stream input and frame-word output of the 1:4 TDM demux.
// The slave modport is the demux's view of the bus and the master modport is the peer's view.
interface tdm_demux_1_4_if #(
    parameter int W = 1
);
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_sof;
    logic [4*W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer. It aligns to a start-of-frame marker, gathers four slots into
// one frame word and presents that word through a valid/ready output register.
module tdm_demux_1_4 #(
    parameter int W = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    tdm_demux_1_4_if.slave  bus,
    output logic            locked,
    output logic            sync_err,
    output logic            overflow,
    input  logic            ovf_clr
);
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t         r_state, w_next_state;
    logic [1:0]     r_slot, w_slot_next;
    logic [3*W-1:0] r_asm, w_asm_next;
    logic [4*W-1:0] r_out_data, w_frame;
    logic           r_out_valid, r_sync_err, r_overflow;
    logic           w_store, w_err, w_complete, w_accept, w_load, w_drop;
    logic [1:0]     w_lane;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_slot  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_slot  <= w_slot_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_slot_next  = r_slot;
        if (bus.in_valid) begin
            case (r_state)
                HUNT: if (bus.in_sof) begin
                    w_next_state = LOCKED;
                    w_slot_next  = 2'd1;
                end
                LOCKED: begin
                    if (bus.in_sof) begin
                        w_slot_next = 2'd1;
                    end else if (r_slot == 2'd0) begin
                        w_next_state = HUNT;
                        w_slot_next  = 2'd0;
                    end else begin
                        w_slot_next = r_slot + 2'd1;
                    end
                end
                default: w_next_state = HUNT;
            endcase
        end
    end

    // A SOF beat always restarts the frame at lane 0. A missing SOF at slot 0 drops the beat.
    always_comb begin
        w_store    = 1'b0;
        w_lane     = 2'd0;
        w_err      = 1'b0;
        w_complete = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                HUNT: w_store = bus.in_sof;
                LOCKED: begin
                    if (bus.in_sof) begin
                        w_store = 1'b1;
                        w_err   = (r_slot != 2'd0);
                    end else if (r_slot == 2'd0) begin
                        w_err = 1'b1;
                    end else begin
                        w_store    = 1'b1;
                        w_lane     = r_slot;
                        w_complete = (r_slot == 2'd3);
                    end
                end
                default: ;
            endcase
        end
    end

    // Lane 3 never lands in the assembly register; it goes straight into the frame word.
    always_comb begin
        w_asm_next = r_asm;
        if (w_err && bus.in_sof) w_asm_next = '0;
        for (int i = 0; i < 3; i++) begin
            if (w_store && (w_lane == 2'(i))) w_asm_next[i*W +: W] = bus.in_data;
        end
    end

    assign w_frame  = {bus.in_data, r_asm};
    assign w_accept = r_out_valid & bus.out_ready;
    assign w_load   = w_complete & (~r_out_valid | w_accept);
    assign w_drop   = w_complete & ~w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_asm      <= w_asm_next;
            r_sync_err <= w_err;
            if (w_load) begin
                r_out_data  <= w_frame;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            // A new drop wins over a clear in the same cycle.
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign locked        = (r_state == LOCKED);
    assign sync_err      = r_sync_err;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed bench for tdm_demux_1_4: a W=1 instance for the basic frame, and a W=8 instance
// for gaps, backpressure, overflow, handover, sync errors and async reset.
module tb_tdm_demux_1_4;
    logic clk = 1'b0;
    logic rst_n;
    logic ovf_clr1, ovf_clr8;
    logic locked1, sync_err1, overflow1;
    logic locked8, sync_err8, overflow8;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    tdm_demux_1_4_if #(.W(1)) bus1 ();
    tdm_demux_1_4_if #(.W(8)) bus8 ();

    tdm_demux_1_4 #(.W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .locked(locked1), .sync_err(sync_err1), .overflow(overflow1), .ovf_clr(ovf_clr1)
    );

    tdm_demux_1_4 #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8.slave),
        .locked(locked8), .sync_err(sync_err8), .overflow(overflow8), .ovf_clr(ovf_clr8)
    );

    // Inputs change on the falling edge and outputs are sampled on the next falling edge.
    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic beat1(input logic sof, input logic d);
        bus1.in_valid = 1'b1;
        bus1.in_sof   = sof;
        bus1.in_data  = d;
        cycle();
        bus1.in_valid = 1'b0;
        bus1.in_sof   = 1'b0;
    endtask

    task automatic beat8(input logic sof, input logic [7:0] d);
        bus8.in_valid = 1'b1;
        bus8.in_sof   = sof;
        bus8.in_data  = d;
        cycle();
        bus8.in_valid = 1'b0;
        bus8.in_sof   = 1'b0;
    endtask

    task automatic check_frame8(input string name, input logic [31:0] exp_data);
        vectors++;
        if (bus8.out_valid !== 1'b1 || bus8.out_data !== exp_data) begin
            miscompares++;
            $display("FAIL %s: out_valid=%b out_data=%h, required out_valid=1 out_data=%h",
                     name, bus8.out_valid, bus8.out_data, exp_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        vectors++;
        if (bus1.out_valid !== 1'b0 || bus1.out_data !== 4'h0 || locked1 !== 1'b0 ||
            sync_err1 !== 1'b0 || overflow1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w1: valid=%b data=%h locked=%b serr=%b ovf=%b, required all 0",
                     bus1.out_valid, bus1.out_data, locked1, sync_err1, overflow1);
        end
        vectors++;
        if (bus8.out_valid !== 1'b0 || bus8.out_data !== 32'h0 || locked8 !== 1'b0 ||
            sync_err8 !== 1'b0 || overflow8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w8: valid=%b data=%h locked=%b serr=%b ovf=%b, required all 0",
                     bus8.out_valid, bus8.out_data, locked8, sync_err8, overflow8);
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic_frame();
        bus1.out_ready = 1'b1;
        beat1(1'b1, 1'b1);
        vectors++;
        if (locked1 !== 1'b1 || bus1.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_lock: locked=%b out_valid=%b, required locked=1 out_valid=0",
                     locked1, bus1.out_valid);
        end
        beat1(1'b0, 1'b0);
        beat1(1'b0, 1'b1);
        beat1(1'b0, 1'b1);
        vectors++;
        if (bus1.out_valid !== 1'b1 || bus1.out_data !== 4'b1101) begin
            miscompares++;
            $display("FAIL basic_frame: out_valid=%b out_data=%b, required out_valid=1 out_data=1101",
                     bus1.out_valid, bus1.out_data);
        end
        cycle();
        vectors++;
        if (bus1.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_accept: out_valid=%b, required 0", bus1.out_valid);
        end
    endtask

    task automatic test_gapped_backpressure();
        bus8.out_ready = 1'b0;
        beat8(1'b1, 8'h11);
        cycle();
        beat8(1'b0, 8'h22);
        cycle();
        cycle();
        beat8(1'b0, 8'h33);
        cycle();
        beat8(1'b0, 8'h44);
        check_frame8("gapped_frame", 32'h44332211);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_frame8("backpressure_hold", 32'h44332211);
        end
        bus8.out_ready = 1'b1;
        cycle();
        vectors++;
        if (bus8.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_accept: out_valid=%b, required 0", bus8.out_valid);
        end
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        bus8.out_ready = 1'b0;
        beat8(1'b1, 8'h01); beat8(1'b0, 8'h02); beat8(1'b0, 8'h03); beat8(1'b0, 8'h04);
        check_frame8("ovf_frame_a", 32'h04030201);
        beat8(1'b1, 8'h05); beat8(1'b0, 8'h06); beat8(1'b0, 8'h07); beat8(1'b0, 8'h08);
        check_frame8("ovf_keeps_a", 32'h04030201);
        vectors++;
        if (overflow8 !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: overflow=%b, required 1", overflow8);
        end
        ovf_clr8       = 1'b1;
        bus8.out_ready = 1'b1;
        cycle();
        ovf_clr8       = 1'b0;
        bus8.out_ready = 1'b0;
        vectors++;
        if (overflow8 !== 1'b0 || bus8.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: overflow=%b out_valid=%b, required both 0",
                     overflow8, bus8.out_valid);
        end
    endtask

    task automatic test_handover();
        bus8.out_ready = 1'b0;
        beat8(1'b1, 8'h10); beat8(1'b0, 8'h20); beat8(1'b0, 8'h30); beat8(1'b0, 8'h40);
        check_frame8("handover_a", 32'h40302010);
        beat8(1'b1, 8'h50); beat8(1'b0, 8'h60); beat8(1'b0, 8'h70);
        bus8.out_ready = 1'b1;
        beat8(1'b0, 8'h80);
        check_frame8("handover_b", 32'h80706050);
        vectors++;
        if (overflow8 !== 1'b0) begin
            miscompares++;
            $display("FAIL handover_ovf: overflow=%b, required 0", overflow8);
        end
        cycle();
        vectors++;
        if (bus8.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL handover_drain: out_valid=%b, required 0", bus8.out_valid);
        end
    endtask

    task automatic test_sync_errors();
        bus8.out_ready = 1'b1;
        beat8(1'b1, 8'hA0);
        beat8(1'b0, 8'hA1);
        beat8(1'b1, 8'hB0);
        vectors++;
        if (sync_err8 !== 1'b1 || locked8 !== 1'b1 || bus8.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL early_sof: sync_err=%b locked=%b out_valid=%b, required 1 1 0",
                     sync_err8, locked8, bus8.out_valid);
        end
        cycle();
        vectors++;
        if (sync_err8 !== 1'b0) begin
            miscompares++;
            $display("FAIL early_sof_pulse: sync_err=%b, required 0", sync_err8);
        end
        beat8(1'b0, 8'hB1); beat8(1'b0, 8'hB2); beat8(1'b0, 8'hB3);
        check_frame8("early_sof_frame", 32'hB3B2B1B0);
        cycle();
        beat8(1'b0, 8'hC0);
        vectors++;
        if (sync_err8 !== 1'b1 || locked8 !== 1'b0) begin
            miscompares++;
            $display("FAIL missing_sof: sync_err=%b locked=%b, required sync_err=1 locked=0",
                     sync_err8, locked8);
        end
        for (int i = 1; i <= 4; i++) begin
            beat8(1'b0, 8'hC0 + 8'(i));
            vectors++;
            if (sync_err8 !== 1'b0 || locked8 !== 1'b0 || bus8.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hunt_discard: sync_err=%b locked=%b out_valid=%b, required all 0",
                         sync_err8, locked8, bus8.out_valid);
            end
        end
        beat8(1'b1, 8'hD0); beat8(1'b0, 8'hD1); beat8(1'b0, 8'hD2); beat8(1'b0, 8'hD3);
        check_frame8("relock_frame", 32'hD3D2D1D0);
        cycle();
    endtask

    task automatic test_async_reset();
        bus8.out_ready = 1'b0;
        beat8(1'b1, 8'hE0); beat8(1'b0, 8'hE1); beat8(1'b0, 8'hE2); beat8(1'b0, 8'hE3);
        check_frame8("pre_reset_frame", 32'hE3E2E1E0);
        beat8(1'b1, 8'hF0);
        beat8(1'b0, 8'hF1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus8.out_valid !== 1'b0 || bus8.out_data !== 32'h0 || locked8 !== 1'b0 ||
            sync_err8 !== 1'b0 || overflow8 !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b data=%h locked=%b serr=%b ovf=%b, required all 0",
                     bus8.out_valid, bus8.out_data, locked8, sync_err8, overflow8);
        end
        cycle();
        rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        beat8(1'b1, 8'h12); beat8(1'b0, 8'h34); beat8(1'b0, 8'h56); beat8(1'b0, 8'h78);
        check_frame8("post_reset_frame", 32'h78563412);
    endtask

    initial begin
        rst_n          = 1'b0;
        ovf_clr1       = 1'b0;
        ovf_clr8       = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_sof    = 1'b0;
        bus1.in_data   = 1'b0;
        bus1.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_sof    = 1'b0;
        bus8.in_data   = 8'h00;
        bus8.out_ready = 1'b0;

        test_reset();
        test_basic_frame();
        test_gapped_backpressure();
        test_overflow();
        test_handover();
        test_sync_errors();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
